// File: rtl/seg_scan_driver.sv
// Eight-digit multiplexed seven-segment scanner, common-anode, active-low.
// Codes and decimal points are snapshotted once per frame so a frame never tears.
module seg_scan_driver #(
   parameter int DIV   = 50000,
   parameter int BLANK = 500
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic [3:0] bit_7,
   input  logic [3:0] bit_6,
   input  logic [3:0] bit_5,
   input  logic [3:0] bit_4,
   input  logic [3:0] bit_3,
   input  logic [3:0] bit_2,
   input  logic [3:0] bit_1,
   input  logic [3:0] bit_0,
   input  logic [7:0] dp_mask,
   output logic [7:0] sel,
   output logic [7:0] seg,
   output logic       frame_done
);

   localparam int CW = $clog2(DIV);

   logic [CW-1:0]   r_cnt;
   logic [2:0]      r_idx;
   logic [7:0][3:0] r_code;
   logic [7:0]      r_dp;
   logic [7:0]      r_sel;
   logic [7:0]      r_seg;
   logic            r_fd;

   logic            w_last;
   logic            w_frame_end;
   logic            w_pre_end;
   logic            w_active;
   logic [3:0]      w_code;
   logic [6:0]      w_dec;
   logic [7:0]      w_sel;

   assign w_last      = (r_cnt == CW'(DIV - 1));
   assign w_frame_end = w_last && (r_idx == 3'd0);
   assign w_pre_end   = (r_cnt == CW'(DIV - 2)) && (r_idx == 3'd0);
   assign w_active    = (r_cnt >= CW'(BLANK));
   assign w_code      = r_code[r_idx];
   assign w_sel       = ~(8'b1 << r_idx);

   always_comb begin
      w_dec = 7'h7F;
      case (w_code)
         4'd0:    w_dec = 7'h40;
         4'd1:    w_dec = 7'h79;
         4'd2:    w_dec = 7'h24;
         4'd3:    w_dec = 7'h30;
         4'd4:    w_dec = 7'h19;
         4'd5:    w_dec = 7'h12;
         4'd6:    w_dec = 7'h02;
         4'd7:    w_dec = 7'h78;
         4'd8:    w_dec = 7'h00;
         4'd9:    w_dec = 7'h10;
         4'd11:   w_dec = 7'h3F;
         default: w_dec = 7'h7F;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_cnt  <= '0;
         r_idx  <= 3'd7;
         r_code <= {8{4'd10}};
         r_dp   <= 8'h00;
         r_sel  <= 8'hFF;
         r_seg  <= 8'hFF;
         r_fd   <= 1'b0;
      end else begin
         r_cnt <= w_last ? '0 : r_cnt + 1'b1;
         if (w_last) r_idx <= r_idx - 3'd1;
         if (w_frame_end) begin
            r_code <= {bit_7, bit_6, bit_5, bit_4,
                       bit_3, bit_2, bit_1, bit_0};
            r_dp   <= dp_mask;
         end
         // outputs trail the counter/index by one cycle
         if (w_active) begin
            r_sel <= w_sel;
            r_seg <= {~r_dp[r_idx], w_dec};
         end else begin
            r_sel <= 8'hFF;
            r_seg <= 8'hFF;
         end
         r_fd <= w_pre_end;
      end
   end

   assign sel        = r_sel;
   assign seg        = r_seg;
   assign frame_done = r_fd;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver at DIV=8, BLANK=2.
// Expected segment patterns per slot are hand-decoded constants.
module tb_seg_scan_driver;

   localparam int DIV   = 8;
   localparam int BLANK = 2;

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic [3:0] bit_7, bit_6, bit_5, bit_4;
   logic [3:0] bit_3, bit_2, bit_1, bit_0;
   logic [7:0] dp_mask;
   logic [7:0] sel;
   logic [7:0] seg;
   logic       frame_done;

   int errors = 0;
   int checks = 0;

   always #5 sys_clk = ~sys_clk;

   seg_scan_driver #(.DIV(DIV), .BLANK(BLANK)) dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .bit_7      (bit_7),
      .bit_6      (bit_6),
      .bit_5      (bit_5),
      .bit_4      (bit_4),
      .bit_3      (bit_3),
      .bit_2      (bit_2),
      .bit_1      (bit_1),
      .bit_0      (bit_0),
      .dp_mask    (dp_mask),
      .sel        (sel),
      .seg        (seg),
      .frame_done (frame_done)
   );

   task automatic set_in(input logic [31:0] c, input logic [7:0] d);
      {bit_7, bit_6, bit_5, bit_4, bit_3, bit_2, bit_1, bit_0} = c;
      dp_mask = d;
   endtask

   function automatic bit legal7(input logic [6:0] v);
      case (v)
         7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
         7'h02, 7'h78, 7'h00, 7'h10, 7'h3F, 7'h7F: legal7 = 1'b1;
         default: legal7 = 1'b0;
      endcase
   endfunction

   // eseg: slot 0 (digit 7) in the top byte; n cycles from frame start
   task automatic run_frame(input string nm, input logic [63:0] eseg,
                            input int n, input int chg_pos,
                            input logic [31:0] cc, input logic [7:0] cd);
      logic [7:0] esel, eg;
      logic       efd;
      for (int p = 0; p < n; p++) begin
         int s = p / 8;
         int q = p % 8;
         @(posedge sys_clk); #1;
         if (q < BLANK) begin
            esel = 8'hFF;
            eg   = 8'hFF;
         end else begin
            esel = ~(8'b1 << (7 - s));
            eg   = eseg[63 - 8*s -: 8];
         end
         efd = (p == 62);
         checks++;
         if (sel !== esel) begin
            errors++;
            $display("FAIL %s sel pos=%0d got=%h exp=%h", nm, p, sel, esel);
         end
         checks++;
         if (seg !== eg) begin
            errors++;
            $display("FAIL %s seg pos=%0d got=%h exp=%h", nm, p, seg, eg);
         end
         checks++;
         if (frame_done !== efd) begin
            errors++;
            $display("FAIL %s frame_done pos=%0d got=%b exp=%b",
                     nm, p, frame_done, efd);
         end
         if (p == chg_pos) set_in(cc, cd);
      end
   endtask

   task automatic check_idle(input string nm);
      checks++;
      if (sel !== 8'hFF) begin
         errors++;
         $display("FAIL %s sel got=%h exp=ff", nm, sel);
      end
      checks++;
      if (seg !== 8'hFF) begin
         errors++;
         $display("FAIL %s seg got=%h exp=ff", nm, seg);
      end
      checks++;
      if (frame_done !== 1'b0) begin
         errors++;
         $display("FAIL %s frame_done got=%b exp=0", nm, frame_done);
      end
   endtask

   task automatic test_reset();
      set_in(32'h18A23B56, 8'h00);
      sys_rst = 1'b1;
      repeat (3) @(posedge sys_clk);
      #1;
      check_idle("reset");
      sys_rst = 1'b0;
   endtask

   task automatic test_blank_frame();
      run_frame("blank_frame", {8{8'hFF}}, 64, -1, 32'h0, 8'h0);
   endtask

   task automatic test_scan_frame();
      run_frame("scan_frame", 64'hF980FFA4B0BF9282, 64, -1, 32'h0, 8'h0);
   endtask

   task automatic test_snapshot_hold();
      run_frame("hold_cur", 64'hF980FFA4B0BF9282, 64, 27,
                32'h18A93B56, 8'h00);
      run_frame("hold_next", 64'hF980FF90B0BF9282, 64, 0,
                32'h18A93B56, 8'h60);
   endtask

   task automatic test_dp();
      run_frame("dp", 64'hF9007F90B0BF9282, 64, 0, 32'h047CDEF9, 8'h00);
   endtask

   task automatic test_all_codes();
      run_frame("codes", 64'hC099F8FFFFFFFF90, 64, -1, 32'h0, 8'h0);
   endtask

   task automatic test_reset_mid();
      run_frame("pre_rst", 64'hC099F8FFFFFFFF90, 37, -1, 32'h0, 8'h0);
      sys_rst = 1'b1;
      @(posedge sys_clk); #1;
      check_idle("mid_rst");
      sys_rst = 1'b0;
      run_frame("post_rst_blank", {8{8'hFF}}, 64, -1, 32'h0, 8'h0);
      run_frame("post_rst_live", 64'hC099F8FFFFFFFF90, 64, -1, 32'h0, 8'h0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 10000; i++) begin
         sys_rst = ($urandom_range(0, 499) == 0);
         set_in($urandom, 8'($urandom));
         @(posedge sys_clk); #1;
         checks++;
         if (!(sel == 8'hFF || $onehot(~sel))) begin
            errors++;
            $display("FAIL rand_sel cyc=%0d got=%h exp=onehot-low", i, sel);
         end
         checks++;
         if (sel == 8'hFF ? (seg !== 8'hFF) : !legal7(seg[6:0])) begin
            errors++;
            $display("FAIL rand_seg cyc=%0d got=%h sel=%h exp=table",
                     i, seg, sel);
         end
      end
      sys_rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_blank_frame();
      test_scan_frame();
      test_snapshot_hold();
      test_dp();
      test_all_codes();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
